vector_execute_unit: RTL and testbench

//  Parametrised execute stage: scalar + multi-cycle vector ALU, forwarding muxes, EX/MEM output register.

---
 rtl/vexu_pkg.sv | 28 ++
 rtl/vexu_lane_alu.sv | 53 +++++
 rtl/vector_execute_unit.sv | 208 ++++++++++++++++++++
 tb/tb_vector_execute_unit.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vexu_pkg.sv
// Shared types for the vector execute unit: ALU opcodes, forward selects, FSM states.
package vexu_pkg;

  typedef enum logic [4:0] {
    OpAdd   = 5'd0,
    OpSub   = 5'd1,
    OpAnd   = 5'd2,
    OpOr    = 5'd3,
    OpXor   = 5'd4,
    OpSll   = 5'd5,
    OpSrl   = 5'd6,
    OpPassb = 5'd7
  } alu_op_e;

  // Code 3 is reserved and behaves like FwdReg.
  typedef enum logic [1:0] {
    FwdReg  = 2'd0,
    FwdWb   = 2'd1,
    FwdMem  = 2'd2,
    FwdRsvd = 2'd3
  } fwd_sel_e;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StVbusy = 1'b1
  } state_e;

endpackage

// File: rtl/vexu_lane_alu.sv
// One combinational DATA_W-wide ALU lane.
// Build option VEXU_SATURATE_EN: vector lanes (IS_VECTOR=1) saturate unsigned ADD/SUB;
// scalar lanes always wrap.
module vexu_lane_alu
  import vexu_pkg::*;
#(
  parameter int unsigned DATA_W    = 8,
  parameter bit          IS_VECTOR = 1'b0
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  alu_op_e           op,
  output logic [DATA_W-1:0] y
);

  localparam int unsigned ShW = $clog2(DATA_W);

`ifdef VEXU_SATURATE_EN
  localparam bit Saturate = IS_VECTOR;
`else
  localparam bit Saturate = 1'b0 & IS_VECTOR;
`endif

  logic [DATA_W:0] sum;
  logic [DATA_W:0] diff;

  // Extra MSB holds carry-out / borrow for saturation.
  assign sum  = {1'b0, a} + {1'b0, b};
  assign diff = {1'b0, a} - {1'b0, b};

  // Opcode decode; unknown opcodes yield zero.
  always_comb begin
    y = '0;
    case (op)
      OpAdd: begin
        y = sum[DATA_W-1:0];
        if (Saturate && sum[DATA_W]) y = '1;
      end
      OpSub: begin
        y = diff[DATA_W-1:0];
        if (Saturate && diff[DATA_W]) y = '0;
      end
      OpAnd:   y = a & b;
      OpOr:    y = a | b;
      OpXor:   y = a ^ b;
      OpSll:   y = a << b[ShW-1:0];
      OpSrl:   y = a >> b[ShW-1:0];
      OpPassb: y = b;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/vector_execute_unit.sv
// Execute stage: single-cycle scalar ALU plus a chunked multi-cycle vector ALU,
// operand forwarding muxes and the EX/MEM output register.
// Build option VEXU_SATURATE_EN (handled in vexu_lane_alu): saturating vector ADD/SUB.
module vector_execute_unit
  import vexu_pkg::*;
#(
  parameter int unsigned DATA_W          = 8,
  parameter int unsigned LANES           = 16,
  parameter int unsigned LANES_PER_CYCLE = 4,
  parameter int unsigned REG_ADDR_W      = 5
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      is_vector,
  input  logic [4:0]                alu_op,
  input  logic [1:0]                fwd_sel_a,
  input  logic [1:0]                fwd_sel_b,
  input  logic [DATA_W-1:0]         src_a,
  input  logic [DATA_W-1:0]         src_b,
  input  logic [DATA_W-1:0]         wb_data,
  input  logic [DATA_W-1:0]         mem_data,
  input  logic [LANES*DATA_W-1:0]   vsrc_a,
  input  logic [LANES*DATA_W-1:0]   vsrc_b,
  input  logic [LANES*DATA_W-1:0]   wb_vdata,
  input  logic [LANES*DATA_W-1:0]   mem_vdata,
  input  logic [REG_ADDR_W-1:0]     rd_in,
  input  logic                      wre_in,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [DATA_W-1:0]         result,
  output logic [LANES*DATA_W-1:0]   vresult,
  output logic [REG_ADDR_W-1:0]     rd_out,
  output logic                      wre_out,
  output logic                      vwre_out
);

  localparam int unsigned VW        = LANES * DATA_W;
  localparam int unsigned CW        = LANES_PER_CYCLE * DATA_W;
  localparam int unsigned NumChunks = LANES / LANES_PER_CYCLE;
  localparam int unsigned ChunkW    = (NumChunks > 1) ? $clog2(NumChunks) : 1;

  if (LANES % LANES_PER_CYCLE != 0) begin : g_bad_cfg
    $error("vector_execute_unit: LANES must be a multiple of LANES_PER_CYCLE");
  end

  state_e                state_q, state_d;
  logic [ChunkW-1:0]     chunk_q, chunk_d;
  logic [VW-1:0]         va_q, vb_q;
  logic [VW-1:0]         vstage_q, vstage_d;
  alu_op_e               vop_q;
  logic [REG_ADDR_W-1:0] vrd_q;
  logic                  vwre_q;
  logic                  out_valid_q, out_valid_d;
  logic [DATA_W-1:0]     result_q;
  logic [VW-1:0]         vresult_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic                  wre_q;
  logic                  vwre_out_q;

  alu_op_e           cur_op;
  logic [DATA_W-1:0] op_a, op_b, scalar_y;
  logic [VW-1:0]     vop_a, vop_b;
  logic [CW-1:0]     chunk_a, chunk_b, lane_y;
  int unsigned       chunk_base;
  logic              accept, scalar_accept, vector_accept, last_chunk, vector_done;

  assign cur_op        = alu_op_e'(alu_op);
  assign in_ready      = (state_q == StIdle) && (!out_valid_q || out_ready);
  assign accept        = in_valid && in_ready;
  assign scalar_accept = accept && !is_vector;
  assign vector_accept = accept && is_vector;
  assign last_chunk    = (chunk_q == ChunkW'(NumChunks - 1));
  assign vector_done   = (state_q == StVbusy) && last_chunk;

  // Operand A forwarding mux (scalar and vector share the select).
  always_comb begin
    op_a  = src_a;
    vop_a = vsrc_a;
    case (fwd_sel_e'(fwd_sel_a))
      FwdWb:   begin op_a = wb_data;  vop_a = wb_vdata;  end
      FwdMem:  begin op_a = mem_data; vop_a = mem_vdata; end
      default: begin op_a = src_a;    vop_a = vsrc_a;    end
    endcase
  end

  // Operand B forwarding mux.
  always_comb begin
    op_b  = src_b;
    vop_b = vsrc_b;
    case (fwd_sel_e'(fwd_sel_b))
      FwdWb:   begin op_b = wb_data;  vop_b = wb_vdata;  end
      FwdMem:  begin op_b = mem_data; vop_b = mem_vdata; end
      default: begin op_b = src_b;    vop_b = vsrc_b;    end
    endcase
  end

  vexu_lane_alu #(
    .DATA_W   (DATA_W),
    .IS_VECTOR(1'b0)
  ) u_scalar_alu (
    .a (op_a),
    .b (op_b),
    .op(cur_op),
    .y (scalar_y)
  );

  // Select the current chunk of the latched vector operands.
  assign chunk_base = CW * 32'(chunk_q);
  assign chunk_a    = CW'(va_q >> chunk_base);
  assign chunk_b    = CW'(vb_q >> chunk_base);

  for (genvar l = 0; l < LANES_PER_CYCLE; l++) begin : g_lane
    vexu_lane_alu #(
      .DATA_W   (DATA_W),
      .IS_VECTOR(1'b1)
    ) u_lane_alu (
      .a (chunk_a[l*DATA_W +: DATA_W]),
      .b (chunk_b[l*DATA_W +: DATA_W]),
      .op(vop_q),
      .y (lane_y[l*DATA_W +: DATA_W])
    );
  end

  // FSM next state, chunk counter, staging merge and out_valid handshake.
  always_comb begin
    state_d     = state_q;
    chunk_d     = chunk_q;
    vstage_d    = vstage_q;
    out_valid_d = out_valid_q && !out_ready;
    case (state_q)
      StIdle: begin
        if (vector_accept) begin
          state_d = StVbusy;
          chunk_d = '0;
        end
        if (scalar_accept) out_valid_d = 1'b1;
      end
      StVbusy: begin
        vstage_d = (vstage_q & ~(VW'({CW{1'b1}}) << chunk_base)) | (VW'(lane_y) << chunk_base);
        chunk_d  = chunk_q + ChunkW'(1);
        if (last_chunk) begin
          state_d     = StIdle;
          chunk_d     = '0;
          out_valid_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State, staging and vector operand latches.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      chunk_q     <= '0;
      vstage_q    <= '0;
      va_q        <= '0;
      vb_q        <= '0;
      vop_q       <= OpAdd;
      vrd_q       <= '0;
      vwre_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      chunk_q     <= chunk_d;
      vstage_q    <= vstage_d;
      out_valid_q <= out_valid_d;
      if (vector_accept) begin
        va_q   <= vop_a;
        vb_q   <= vop_b;
        vop_q  <= cur_op;
        vrd_q  <= rd_in;
        vwre_q <= wre_in;
      end
    end
  end

  // EX/MEM output register; only written on completion, so it holds under backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_q   <= '0;
      vresult_q  <= '0;
      rd_q       <= '0;
      wre_q      <= 1'b0;
      vwre_out_q <= 1'b0;
    end else if (scalar_accept) begin
      result_q   <= scalar_y;
      rd_q       <= rd_in;
      wre_q      <= wre_in;
      vwre_out_q <= 1'b0;
    end else if (vector_done) begin
      vresult_q  <= vstage_d;
      rd_q       <= vrd_q;
      wre_q      <= vwre_q;
      vwre_out_q <= vwre_q;
    end
  end

  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign vresult   = vresult_q;
  assign rd_out    = rd_q;
  assign wre_out   = wre_q;
  assign vwre_out  = vwre_out_q;

endmodule

// File: tb/tb_vector_execute_unit.sv
// Directed self-checking bench for vector_execute_unit (DATA_W=8, LANES=16, LPC=4).
module tb_vector_execute_unit;

  logic         clk = 1'b0;
  logic         reset;
  logic         in_valid, in_ready, is_vector;
  logic [4:0]   alu_op;
  logic [1:0]   fwd_sel_a, fwd_sel_b;
  logic [7:0]   src_a, src_b, wb_data, mem_data;
  logic [127:0] vsrc_a, vsrc_b, wb_vdata, mem_vdata;
  logic [4:0]   rd_in;
  logic         wre_in;
  logic         out_valid, out_ready;
  logic [7:0]   result;
  logic [127:0] vresult;
  logic [4:0]   rd_out;
  logic         wre_out, vwre_out;

  int total = 0;
  int bad   = 0;

`ifdef VEXU_SATURATE_EN
  localparam logic [7:0] VaddLane = 8'hFF;
`else
  localparam logic [7:0] VaddLane = 8'h10;
`endif

  vector_execute_unit #(
    .DATA_W         (8),
    .LANES          (16),
    .LANES_PER_CYCLE(4),
    .REG_ADDR_W     (5)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .is_vector(is_vector),
    .alu_op   (alu_op),
    .fwd_sel_a(fwd_sel_a),
    .fwd_sel_b(fwd_sel_b),
    .src_a    (src_a),
    .src_b    (src_b),
    .wb_data  (wb_data),
    .mem_data (mem_data),
    .vsrc_a   (vsrc_a),
    .vsrc_b   (vsrc_b),
    .wb_vdata (wb_vdata),
    .mem_vdata(mem_vdata),
    .rd_in    (rd_in),
    .wre_in   (wre_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .vresult  (vresult),
    .rd_out   (rd_out),
    .wre_out  (wre_out),
    .vwre_out (vwre_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs(input string tag);
    check({tag, " out_valid"}, 128'(out_valid), 128'(0));
    check({tag, " result"},    128'(result),    128'(0));
    check({tag, " vresult"},   vresult,         128'(0));
    check({tag, " rd_out"},    128'(rd_out),    128'(0));
    check({tag, " wre_out"},   128'(wre_out),   128'(0));
    check({tag, " vwre_out"},  128'(vwre_out),  128'(0));
  endtask

  task automatic scalar_op(input logic [4:0] op, input logic [7:0] a, input logic [7:0] b,
                           input logic [4:0] rd);
    in_valid  = 1'b1;
    is_vector = 1'b0;
    alu_op    = op;
    fwd_sel_a = 2'd0;
    fwd_sel_b = 2'd0;
    src_a     = a;
    src_b     = b;
    rd_in     = rd;
    wre_in    = 1'b1;
  endtask

  logic [127:0] vexp;
  logic [127:0] vadd_exp;
  logic [7:0]   srl_tab [8];
  logic [7:0]   b2b_res [6];

  initial begin
    srl_tab = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01};
    // ADD 7F+01, SUB 00-01 (scalar wraps), AND F0&3C, SLL 03<<(0A&7), PASSB 5A, unknown op.
    b2b_res = '{8'h80, 8'hFF, 8'h30, 8'h0C, 8'h5A, 8'h00};
    vadd_exp = {16{VaddLane}};

    reset = 1'b1;
    in_valid = 1'b0; is_vector = 1'b0; alu_op = '0; fwd_sel_a = '0; fwd_sel_b = '0;
    src_a = '0; src_b = '0; wb_data = '0; mem_data = '0;
    vsrc_a = '0; vsrc_b = '0; wb_vdata = '0; mem_vdata = '0;
    rd_in = '0; wre_in = 1'b0; out_ready = 1'b1;
    #1;
    check_zero_outputs("reset");
    step();
    step();
    reset = 1'b0;
    #1;
    check("post-reset in_ready", 128'(in_ready), 128'(1));

    // Scalar ADD 01+02.
    scalar_op(5'd0, 8'h01, 8'h02, 5'd7);
    step();
    in_valid = 1'b0;
    check("sadd out_valid", 128'(out_valid), 128'(1));
    check("sadd result",    128'(result),    128'(8'h03));
    check("sadd rd_out",    128'(rd_out),    128'(5'd7));
    check("sadd wre_out",   128'(wre_out),   128'(1));
    check("sadd vwre_out",  128'(vwre_out),  128'(0));
    step();
    check("sadd valid drop", 128'(out_valid), 128'(0));

    // Forwarding: A from memory, B from writeback, SUB.
    scalar_op(5'd1, 8'hAA, 8'h55, 5'd2);
    fwd_sel_a = 2'd2; mem_data = 8'h10;
    fwd_sel_b = 2'd1; wb_data  = 8'h05;
    step();
    in_valid = 1'b0;
    check("fwd mem/wb sub", 128'(result), 128'(8'h0B));
    // Select 3 falls back to the register operands.
    scalar_op(5'd1, 8'h09, 8'h04, 5'd2);
    fwd_sel_a = 2'd3; fwd_sel_b = 2'd3;
    step();
    in_valid = 1'b0;
    check("fwd sel3 sub", 128'(result), 128'(8'h05));

    // Vector ADD F0+20 on every lane; inputs change after accept to prove latching.
    in_valid = 1'b1; is_vector = 1'b1; alu_op = 5'd0; fwd_sel_a = 2'd0; fwd_sel_b = 2'd0;
    vsrc_a = {16{8'hF0}}; vsrc_b = {16{8'h20}}; wb_vdata = {16{8'h33}}; mem_vdata = {16{8'h44}};
    rd_in = 5'd3; wre_in = 1'b1;
    step();
    in_valid = 1'b0; vsrc_a = '0; vsrc_b = '0;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("vadd busy%0d in_ready", k), 128'(in_ready), 128'(0));
      check($sformatf("vadd busy%0d out_valid", k), 128'(out_valid), 128'(0));
      step();
    end
    check("vadd out_valid", 128'(out_valid), 128'(1));
    check("vadd vresult",   vresult,         vadd_exp);
    check("vadd rd_out",    128'(rd_out),    128'(5'd3));
    check("vadd vwre_out",  128'(vwre_out),  128'(1));
    check("vadd scalar untouched", 128'(result), 128'(8'h05));

    // Backpressure for 3 cycles with a scalar OR pending.
    out_ready = 1'b0;
    scalar_op(5'd3, 8'h0C, 8'h30, 5'd9);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("hold%0d in_ready", k), 128'(in_ready), 128'(0));
      step();
      check($sformatf("hold%0d out_valid", k), 128'(out_valid), 128'(1));
      check($sformatf("hold%0d vresult", k),   vresult,         vadd_exp);
      check($sformatf("hold%0d rd_out", k),    128'(rd_out),    128'(5'd3));
      check($sformatf("hold%0d result", k),    128'(result),    128'(8'h05));
    end
    out_ready = 1'b1;
    #1;
    check("release in_ready", 128'(in_ready), 128'(1));
    step();
    in_valid = 1'b0;
    check("release out_valid", 128'(out_valid), 128'(1));
    check("release result",    128'(result),    128'(8'h3C));
    check("release rd_out",    128'(rd_out),    128'(5'd9));
    check("release vwre_out",  128'(vwre_out),  128'(0));
    check("vresult kept",      vresult,         vadd_exp);
    step();
    check("release drop", 128'(out_valid), 128'(0));

    // Vector SRL: lane i = 0x80 >> (i & 7); also exercises ordering of chunks.
    in_valid = 1'b1; is_vector = 1'b1; alu_op = 5'd6; rd_in = 5'd12; wre_in = 1'b1;
    vsrc_a = {16{8'h80}};
    for (int i = 0; i < 16; i++) begin
      vsrc_b[i*8 +: 8] = 8'(i);
      vexp[i*8 +: 8]   = srl_tab[i % 8];
    end
    step();
    in_valid = 1'b0;
    for (int k = 0; k < 4; k++) step();
    check("vsrl out_valid", 128'(out_valid), 128'(1));
    check("vsrl vresult",   vresult,         vexp);
    check("vsrl rd_out",    128'(rd_out),    128'(5'd12));

    // Reset in the 2nd busy cycle of a vector op.
    in_valid = 1'b1; is_vector = 1'b1; alu_op = 5'd0;
    vsrc_a = {16{8'h11}}; vsrc_b = {16{8'h22}};
    step();
    in_valid = 1'b0;
    step();
    reset = 1'b1;
    #1;
    check_zero_outputs("mid-reset");
    step();
    reset = 1'b0;
    #1;
    check("after reset in_ready", 128'(in_ready), 128'(1));
    for (int k = 0; k < 5; k++) begin
      step();
      check($sformatf("no stale valid%0d", k), 128'(out_valid), 128'(0));
    end

    // Back-to-back scalar ops with out_ready held high, plus an unknown opcode.
    for (int k = 0; k < 6; k++) begin
      case (k)
        0: scalar_op(5'd0,  8'h7F, 8'h01, 5'd1);
        1: scalar_op(5'd1,  8'h00, 8'h01, 5'd2);
        2: scalar_op(5'd2,  8'hF0, 8'h3C, 5'd3);
        3: scalar_op(5'd5,  8'h03, 8'h0A, 5'd4);
        4: scalar_op(5'd7,  8'h11, 8'h5A, 5'd5);
        default: scalar_op(5'd31, 8'hFF, 8'hFF, 5'd6);
      endcase
      check($sformatf("b2b%0d in_ready", k), 128'(in_ready), 128'(1));
      step();
      check($sformatf("b2b%0d out_valid", k), 128'(out_valid), 128'(1));
      check($sformatf("b2b%0d result", k),    128'(result),    128'(b2b_res[k]));
      check($sformatf("b2b%0d rd_out", k),    128'(rd_out),    128'(k + 1));
      check($sformatf("b2b%0d wre_out", k),   128'(wre_out),   128'(1));
    end
    in_valid = 1'b0;
    step();
    check("b2b drain", 128'(out_valid), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
